// File: rtl/adc_lvds_capture_if.sv
// Sample-word stream from the ADC capture block towards the DDR3 input FIFO.
interface adc_lvds_capture_if #(
    parameter int unsigned DATA_W = 128
);
    logic [DATA_W-1:0] o_data;
    logic              o_rdy;

    modport master (output o_data, output o_rdy);
    modport slave  (input  o_data, input  o_rdy);
endinterface

// File: rtl/adc_lvds_capture.sv
// Burst acquisition for dual-channel serial ADCs: drives CNV_n/SCK strobes,
// deserialises the SDO lanes and emits one packed word per conversion.
module adc_lvds_capture #(
    parameter int unsigned N_LANES     = 8,
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned CNV_CYCLES  = 2,
    parameter int unsigned CONV_CYCLES = 30,
    parameter int unsigned SCK_HALF    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [31:0]            i_samples_count,
    input  logic                   i_debug_en,
    input  logic                   i_init_calib_complete,
    input  logic [N_LANES-1:0]     i_ADC_SDO,
    output logic [N_LANES/2-1:0]   o_ADC_SCK,
    output logic [N_LANES/2-1:0]   o_ADC_CNV_n,
    output logic                   o_finished,
    output logic                   o_start_led,
    adc_lvds_capture_if.master     fifo_if
);

    localparam int unsigned N_ADC   = N_LANES / 2;
    localparam int unsigned CNT_MAX = (CONV_CYCLES > CNV_CYCLES) ? CONV_CYCLES : CNV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(SAMPLE_BITS + 1);
    localparam int unsigned HALF_W  = $clog2(SCK_HALF + 1);

    typedef enum logic [2:0] {IDLE, CNV, WAIT, SHIFT, PUSH, DONE} state_t;

    typedef logic [N_LANES-1:0][SAMPLE_BITS-1:0] lanes_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic                phase_q, phase_d;      // 1: SCK high phase
    logic [31:0]         remaining_q, remaining_d;
    logic [31:0]         idx_q, idx_d;
    lanes_t              shreg_q, shreg_d;
    lanes_t              data_q, data_d;
    logic                sck_q, sck_d;
    logic                cap_q, cap_d;          // last cycle of a visible SCK high phase
    logic                cnv_n_q, cnv_n_d;
    logic                rdy_q, rdy_d;
    logic                fin_q, fin_d;
    logic                led_q, led_d;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            half_q      <= '0;
            phase_q     <= 1'b0;
            remaining_q <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            sck_q       <= 1'b0;
            cap_q       <= 1'b0;
            cnv_n_q     <= 1'b1;
            rdy_q       <= 1'b0;
            fin_q       <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            half_q      <= half_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            sck_q       <= sck_d;
            cap_q       <= cap_d;
            cnv_n_q     <= cnv_n_d;
            rdy_q       <= rdy_d;
            fin_q       <= fin_d;
            led_q       <= led_d;
        end
    end

    // Next-state sequencing and output decode; outputs lag the state by one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        half_d      = half_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;

        unique case (state_q)
            IDLE: begin
                if (i_start && i_init_calib_complete) begin
                    remaining_d = i_samples_count;
                    idx_d       = '0;
                    cnt_d       = '0;
                    state_d     = (i_samples_count == 32'd0) ? DONE : CNV;
                end
            end
            CNV: begin
                if (cnt_q == CNT_W'(CNV_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    half_d  = '0;
                    phase_d = 1'b1;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (half_q == HALF_W'(SCK_HALF - 1)) begin
                    half_d = '0;
                    if (phase_q) begin
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b1;
                        if (bit_q == BIT_W'(SAMPLE_BITS - 1)) begin
                            phase_d = 1'b0;
                            state_d = PUSH;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
            end
            PUSH: begin
                idx_d       = idx_q + 32'd1;
                remaining_d = remaining_q - 32'd1;
                cnt_d       = '0;
                state_d     = (remaining_q > 32'd1) ? CNV : DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Shift on the last cycle SCK is visibly high, so SDO has settled since the prior fall.
        if (cap_q) begin
            for (int unsigned v = 0; v < N_LANES; v++) begin
                shreg_d[v] = {shreg_q[v][SAMPLE_BITS-2:0], i_ADC_SDO[v]};
            end
        end

        if (state_q == PUSH) begin
            for (int unsigned v = 0; v < N_LANES; v++) begin
                data_d[v] = i_debug_en ? (SAMPLE_BITS'(idx_q) + SAMPLE_BITS'(v)) : shreg_q[v];
            end
        end

        sck_d   = (state_q == SHIFT) && phase_q;
        cap_d   = (state_q == SHIFT) && phase_q && (half_q == HALF_W'(SCK_HALF - 1));
        cnv_n_d = (state_q != CNV);
        rdy_d   = (state_q == PUSH);
        fin_d   = (state_q == DONE);
        led_d   = (state_q == CNV) || (state_q == WAIT) || (state_q == SHIFT) || (state_q == PUSH);
    end

    assign o_ADC_SCK      = {N_ADC{sck_q}};
    assign o_ADC_CNV_n    = {N_ADC{cnv_n_q}};
    assign o_finished     = fin_q;
    assign o_start_led    = led_q;
    assign fifo_if.o_data = data_q;
    assign fifo_if.o_rdy  = rdy_q;

endmodule
